// File: rtl/zap_fetch_prefetch_queue_pkg.sv
// Shared types for the fetch prefetch queue.
// Purpose : entry layout {abort,fiq,irq,pc,instr} and queue sizing constants.
// Ports   : none (package).
package zap_fetch_prefetch_queue_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_W     = 32;
  localparam int FQ_DEPTH = 2;

  // One queued fetch. The packed order makes the entry exactly 67 bits with
  // the instruction in the low word.
  typedef struct packed {
    logic              abort;
    logic              fiq;
    logic              irq;
    logic [PC_W-1:0]   pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Builds an entry from its fields; keeps call sites readable.
  function automatic entry_t make_entry(input logic abort, input logic fiq,
                                        input logic irq, input logic [PC_W-1:0] pc,
                                        input logic [INSTR_W-1:0] instr);
    entry_t e;
    e.abort = abort;
    e.fiq   = fiq;
    e.irq   = irq;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/zap_fetch_prefetch_queue_if.sv
// Valid/stall channel carrying one queue entry.
// Purpose : used twice, fetch->queue (queue is slave) and queue->decode (queue is master).
// Ports   : vld (entry present), dat (entry), stall (receiver refuses / holds).
interface zap_fetch_prefetch_queue_if;
  import zap_fetch_prefetch_queue_pkg::*;

  logic   vld;
  entry_t dat;
  logic   stall;

  // Producer side: drives the entry, obeys stall.
  modport master (output vld, output dat, input stall);
  // Consumer side: takes the entry, asserts stall to refuse it.
  modport slave  (input vld, input dat, output stall);

endinterface

// File: rtl/zap_fetch_prefetch_queue_fifo_core.sv
// Generic register-array FIFO with flush, hold and occupancy count.
// Latency : a word pushed into an empty FIFO is visible at o_head_dat next cycle.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
// Ports   : i_clk, i_reset (sync, active high), i_flush, i_hold, i_push, i_pop,
//           i_dat (write data), o_head_dat (oldest entry), o_count (0..DEPTH).
module zap_sync_fifo_core #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int PTR_W = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_hold,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_head_dat,
  output logic [PTR_W:0]   o_count
);

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic w_advance;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Reset and flush dominate hold; hold freezes pointers, count and storage.
  assign w_advance = !i_reset && !i_flush && !i_hold;
  assign w_full    = (r_count == DEPTH_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = w_advance && i_push && !w_full;
  assign w_pop     = w_advance && i_pop && !w_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is never reset or flushed; emptiness is tracked by count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/zap_fetch_prefetch_queue.sv
// Prefetch queue between fetch and decode: buffers instr/pc/abort/irq/fiq.
// Latency : one cycle from push to head when empty; no input-to-output bypass.
// Backpressure: i_fetch.stall = queue full (register-derived only); decode stall holds head.
// Ports   : i_clk, i_reset (sync, active high);
//           i_fetch  (slave)  : vld/dat from fetch, stall back to fetch;
//           o_decode (master) : vld/dat head entry, stall from decode FSM;
//           i_clear_from_writeback, i_data_stall, i_clear_from_alu,
//           i_stall_from_shifter, i_issue_stall : pipeline flush/hold controls.
module zap_fetch_prefetch_queue
  import zap_fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  zap_fetch_prefetch_queue_if.slave     i_fetch,
  zap_fetch_prefetch_queue_if.master    o_decode,
  input  logic                          i_clear_from_writeback,
  input  logic                          i_data_stall,
  input  logic                          i_clear_from_alu,
  input  logic                          i_stall_from_shifter,
  input  logic                          i_issue_stall
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic               w_flush;
  logic               w_hold;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [ENTRY_W-1:0] w_head;
  logic [PTR_W:0]     w_count;

  // Priority: writeback clear > data stall > ALU clear > shifter/issue hold.
  // The ALU clear is swallowed by a data stall, but an ALU clear still beats
  // the lower shifter/issue holds because the core lets flush override hold.
  assign w_flush = i_clear_from_writeback || (!i_data_stall && i_clear_from_alu);
  assign w_hold  = i_data_stall || i_stall_from_shifter || i_issue_stall;

  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == DEPTH_CNT);

  // Push is refused when full even if a pop happens in the same cycle, so
  // fetch stall never depends on the decode stall.
  assign w_push = i_fetch.vld && !w_full;
  assign w_pop  = !w_empty && !o_decode.stall;

  zap_sync_fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .PTR_W (PTR_W)
  ) u_core (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_flush    (w_flush),
    .i_hold     (w_hold),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_dat      (i_fetch.dat),
    .o_head_dat (w_head),
    .o_count    (w_count)
  );

  // Stale payloads stay in storage after a flush; mask them so an empty
  // queue always presents zeros.
  assign o_decode.vld  = !w_empty;
  assign o_decode.dat  = w_empty ? '0 : entry_t'(w_head);
  assign i_fetch.stall = w_full;

endmodule
